// File: rtl/light_show_sequencer.sv
// Show scheduler: launches one pattern engine at a time, mirrors its lights,
// inserts a dark gap between patterns and forces an advance if an engine hangs.
module light_show_sequencer #(
    parameter int NUM_PATTERNS = 4,
    parameter int CLKS_PER_MS  = 50000,
    parameter int GAP_MS       = 500,
    parameter int TIMEOUT_MS   = 30000,
    localparam int IDX_W       = (NUM_PATTERNS > 2) ? $clog2(NUM_PATTERNS) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic                      skip,
    input  logic [NUM_PATTERNS-1:0]   pattern_finished,
    input  logic [8*NUM_PATTERNS-1:0] pattern_lights,
    output logic [NUM_PATTERNS-1:0]   pattern_go,
    output logic [7:0]                lights,
    output logic [IDX_W-1:0]          active_idx,
    output logic                      busy,
    output logic                      timeout_err
);

    localparam int PRESC_W = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_RUN,
        S_GAP
    } state_t;

    state_t                    state_q, state_d;
    logic [PRESC_W-1:0]        presc_q, presc_d;
    logic [19:0]               ms_q, ms_d;
    logic [NUM_PATTERNS-1:0]   fin_prev_q;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [NUM_PATTERNS-1:0]   go_q, go_d;
    logic [7:0]                lights_q, lights_d;
    logic                      terr_q, terr_d;

    logic                      tick;
    logic                      completion;
    logic                      timeout_hit;
    logic                      gap_done;
    logic [IDX_W-1:0]          idx_inc;

    assign tick        = (presc_q == PRESC_W'(CLKS_PER_MS - 1));
    // A finished that is already high when the engine is launched does not count.
    assign completion  = pattern_finished[idx_q] & ~fin_prev_q[idx_q];
    assign timeout_hit = (ms_q == 20'(TIMEOUT_MS));
    assign gap_done    = (GAP_MS == 0) || (ms_q == 20'(GAP_MS)) || skip;
    assign idx_inc     = (idx_q == IDX_W'(NUM_PATTERNS - 1)) ? '0 : idx_q + IDX_W'(1);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        terr_d  = terr_q;
        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    state_d = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                state_d = S_RUN;
            end
            S_RUN: begin
                if (timeout_hit) begin
                    terr_d = 1'b1;
                end
                if (completion || timeout_hit || skip) begin
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (gap_done) begin
                    state_d = S_LAUNCH;
                    idx_d   = idx_inc;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // Disable wins over every other transition and freezes the index.
        if (!enable) begin
            state_d = S_IDLE;
            idx_d   = idx_q;
        end
    end

    always_comb begin
        presc_d = presc_q + PRESC_W'(1);
        ms_d    = ms_q;
        if (state_d != state_q) begin
            presc_d = '0;
            ms_d    = '0;
        end else if (tick) begin
            presc_d = '0;
            ms_d    = ms_q + 20'd1;
        end
    end

    always_comb begin
        go_d = '0;
        if (state_d == S_LAUNCH) begin
            go_d = NUM_PATTERNS'(1) << idx_d;
        end
        lights_d = '0;
        if (state_q == S_LAUNCH || state_q == S_RUN) begin
            lights_d = pattern_lights[8*idx_q +: 8];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            presc_q    <= '0;
            ms_q       <= '0;
            fin_prev_q <= '0;
            idx_q      <= '0;
            go_q       <= '0;
            lights_q   <= '0;
            terr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            ms_q       <= ms_d;
            fin_prev_q <= pattern_finished;
            idx_q      <= idx_d;
            go_q       <= go_d;
            lights_q   <= lights_d;
            terr_q     <= terr_d;
        end
    end

    assign pattern_go  = go_q;
    assign lights      = lights_q;
    assign active_idx  = idx_q;
    assign busy        = (state_q != S_IDLE);
    assign timeout_err = terr_q;

endmodule

// File: tb/tb_light_show_sequencer.sv
// Randomized and directed bench for light_show_sequencer; a cycle-based reference
// model predicts every output, a separate monitor pops and compares each cycle.
module tb_light_show_sequencer;

    localparam int N   = 3;
    localparam int CPM = 4;
    localparam int GAP = 2;
    localparam int TO  = 10;
    localparam int IW  = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             enable = 1'b0;
    logic             skip = 1'b0;
    logic [N-1:0]     pattern_finished = '0;
    logic [8*N-1:0]   pattern_lights = '0;
    logic [N-1:0]     pattern_go;
    logic [7:0]       lights;
    logic [IW-1:0]    active_idx;
    logic             busy;
    logic             timeout_err;

    light_show_sequencer #(
        .NUM_PATTERNS(N),
        .CLKS_PER_MS (CPM),
        .GAP_MS      (GAP),
        .TIMEOUT_MS  (TO)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .enable          (enable),
        .skip            (skip),
        .pattern_finished(pattern_finished),
        .pattern_lights  (pattern_lights),
        .pattern_go      (pattern_go),
        .lights          (lights),
        .active_idx      (active_idx),
        .busy            (busy),
        .timeout_err     (timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] go;
        logic [7:0]   lt;
        int           idx;
        logic         bsy;
        logic         terr;
    } exp_t;

    exp_t exp_q[$];

    typedef enum {P_IDLE, P_LAUNCH, P_RUN, P_GAP} phase_t;

    // Reference model: time is tracked as whole cycles spent in the current phase.
    phase_t       m_phase;
    int           m_idx;
    int           m_elapsed;
    logic         m_terr;
    logic [N-1:0] m_prev;
    logic [N-1:0] m_go;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic model_step(input logic en, input logic sk, input logic [N-1:0] fin,
                              input logic [8*N-1:0] pl);
        phase_t       nxt;
        int           nidx;
        logic [7:0]   lt;
        logic [N-1:0] one;
        exp_t         e;
        nxt  = m_phase;
        nidx = m_idx;
        one  = 1;
        lt   = (m_phase == P_LAUNCH || m_phase == P_RUN) ? pl[8*m_idx +: 8] : 8'h00;
        case (m_phase)
            P_IDLE:   nxt = P_LAUNCH;
            P_LAUNCH: nxt = P_RUN;
            P_RUN: begin
                if (m_elapsed == TO * CPM) m_terr = 1'b1;
                if ((fin[m_idx] && !m_prev[m_idx]) || m_elapsed == TO * CPM || sk) nxt = P_GAP;
            end
            P_GAP: begin
                if (GAP == 0 || m_elapsed == GAP * CPM || sk) begin
                    nxt  = P_LAUNCH;
                    nidx = (m_idx + 1) % N;
                end
            end
            default: nxt = P_IDLE;
        endcase
        if (!en) begin
            nxt  = P_IDLE;
            nidx = m_idx;
        end
        m_elapsed = (nxt != m_phase) ? 0 : m_elapsed + 1;
        m_phase   = nxt;
        m_idx     = nidx;
        m_prev    = fin;
        m_go      = (nxt == P_LAUNCH) ? (one << nidx) : '0;
        e.go   = m_go;
        e.lt   = lt;
        e.idx  = m_idx;
        e.bsy  = (nxt != P_IDLE);
        e.terr = m_terr;
        exp_q.push_back(e);
    endtask

    task automatic drive(input logic en, input logic sk, input logic [N-1:0] fin,
                         input logic [8*N-1:0] pl);
        @(negedge clk);
        enable           = en;
        skip             = sk;
        pattern_finished = fin;
        pattern_lights   = pl;
        model_step(en, sk, fin, pl);
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        enable = 1'b0;
        skip   = 1'b0;
        #1;
        check("rst_go", 32'(pattern_go), 0);
        check("rst_lights", 32'(lights), 0);
        check("rst_idx", 32'(active_idx), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_terr", 32'(timeout_err), 0);
        m_phase   = P_IDLE;
        m_idx     = 0;
        m_elapsed = 0;
        m_terr    = 1'b0;
        m_prev    = '0;
        m_go      = '0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic run_until_launch(input logic [N-1:0] fin, input logic [8*N-1:0] pl,
                                    input int max_cycles);
        int n;
        n = 0;
        do begin
            drive(1'b1, 1'b0, fin, pl);
            n++;
        end while (m_go == 0 && n < max_cycles);
        check("launch_wait", 32'(pattern_go != 0), 1);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("go", 32'(pattern_go), 32'(e.go));
            check("lights", 32'(lights), 32'(e.lt));
            check("idx", 32'(active_idx), 32'(e.idx));
            check("busy", 32'(busy), 32'(e.bsy));
            check("terr", 32'(timeout_err), 32'(e.terr));
            if (e.go != 0) $display("launch idx=%0d go=%b t=%0t", e.idx, pattern_go, $time);
        end
    end

    initial begin
        logic [8*N-1:0] pl;
        logic [N-1:0]   f;
        logic [N-1:0]   fr;
        logic [8*N-1:0] pr;
        logic           en;
        logic           sk;
        int             mode;

        pl = {8'h3C, 8'h5A, 8'hA5};
        #3;
        do_reset();

        // Basic handoff
        drive(1'b1, 1'b0, 3'b000, pl);
        check("s1_go", 32'(pattern_go), 32'b001);
        drive(1'b1, 1'b0, 3'b000, pl);
        check("s1_lights", 32'(lights), 32'hA5);
        check("s1_go_off", 32'(pattern_go), 0);
        drive(1'b1, 1'b0, 3'b001, pl);
        drive(1'b1, 1'b0, 3'b001, pl);
        check("s1_dark", 32'(lights), 0);
        run_until_launch(3'b001, pl, 20);
        check("s1_idx", 32'(active_idx), 1);
        check("s1_go2", 32'(pattern_go), 32'b010);

        // Wrap around the pattern list
        f = 3'b001;
        for (int k = 1; k < N; k++) begin
            drive(1'b1, 1'b0, f, pl);
            f = f | (3'b001 << k);
            drive(1'b1, 1'b0, f, pl);
            run_until_launch(f, pl, 20);
        end
        check("s2_idx", 32'(active_idx), 0);
        check("s2_go", 32'(pattern_go), 32'b001);

        // Watchdog timeout on engine0
        drive(1'b1, 1'b0, 3'b000, pl);
        run_until_launch(3'b000, pl, 120);
        check("s3_terr", 32'(timeout_err), 1);
        check("s3_idx", 32'(active_idx), 1);

        // Skip in RUN, in GAP and in IDLE
        drive(1'b1, 1'b0, 3'b000, pl);
        drive(1'b1, 1'b1, 3'b000, pl);
        drive(1'b1, 1'b0, 3'b000, pl);
        check("s4_gap_dark", 32'(lights), 0);
        drive(1'b1, 1'b1, 3'b000, pl);
        check("s4_idx", 32'(active_idx), 2);
        check("s4_go", 32'(pattern_go), 32'b100);
        check("s4_terr_sticky", 32'(timeout_err), 1);
        drive(1'b0, 1'b0, 3'b000, pl);
        drive(1'b0, 1'b1, 3'b000, pl);
        drive(1'b0, 1'b1, 3'b000, pl);
        check("s4_idle_busy", 32'(busy), 0);
        check("s4_idle_idx", 32'(active_idx), 2);
        drive(1'b1, 1'b0, 3'b000, pl);
        check("s4_relaunch", 32'(pattern_go), 32'b100);

        // Randomized traffic: normal, quiet (forces timeouts) and stormy modes
        fr   = '0;
        mode = 0;
        for (int c = 0; c < 4000; c++) begin
            if (c % 300 == 0) mode = $urandom_range(0, 2);
            pr = 24'($urandom);
            en = (mode == 2) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 199) != 0);
            sk = (mode == 1) ? 1'b0 :
                 (mode == 2) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 59) == 0);
            if (mode != 1) begin
                for (int i = 0; i < N; i++) begin
                    if ($urandom_range(0, 11) == 0) fr[i] = ~fr[i];
                end
            end
            drive(en, sk, fr, pr);
        end

        do_reset();

        // Stale finished on engine0, foreign pulses on engine2
        drive(1'b1, 1'b0, 3'b001, pl);
        drive(1'b1, 1'b0, 3'b001, pl);
        for (int c = 0; c < 4; c++) begin
            drive(1'b1, 1'b0, (c % 2 == 0) ? 3'b101 : 3'b001, pl);
        end
        check("s5_still_run", 32'(lights), 32'hA5);
        check("s5_idx", 32'(active_idx), 0);
        drive(1'b1, 1'b0, 3'b000, pl);
        drive(1'b1, 1'b0, 3'b001, pl);
        drive(1'b1, 1'b0, 3'b001, pl);
        check("s5_dark", 32'(lights), 0);
        run_until_launch(3'b001, pl, 20);
        check("s5_next", 32'(active_idx), 1);

        // Enable drop mid-RUN, then reset mid-GAP
        drive(1'b1, 1'b0, 3'b000, pl);
        drive(1'b0, 1'b0, 3'b000, pl);
        drive(1'b0, 1'b0, 3'b000, pl);
        check("s6_lights", 32'(lights), 0);
        check("s6_idx", 32'(active_idx), 1);
        check("s6_busy", 32'(busy), 0);
        drive(1'b1, 1'b0, 3'b000, pl);
        check("s6_go", 32'(pattern_go), 32'b010);
        drive(1'b1, 1'b0, 3'b000, pl);
        drive(1'b1, 1'b1, 3'b000, pl);
        drive(1'b1, 1'b0, 3'b000, pl);
        drive(1'b1, 1'b0, 3'b000, pl);
        do_reset();
        drive(1'b1, 1'b0, 3'b000, pl);
        check("s6_post_rst_go", 32'(pattern_go), 32'b001);

        @(posedge clk);
        #2;
        check("queue_empty", 32'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
